freg_ctx_sequencer: RTL and testbench

Context save/restore sequencer for the MicroGT-01 floating-point register file. On a save or restore command (issued by the interrupt/trap logic), it streams all NREG FP registers to or from a word-addressed memory region. Each transfer uses a req/ack handshake, one register per accepted transfer. It drives one read port and the write port of the FP register file, and blocks FPU write-back while active.

---
 rtl/freg_ctx_sequencer.sv | 134 +++++++++++++
 tb/tb_freg_ctx_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freg_ctx_sequencer.sv
// Context save/restore sequencer: streams the FP register file to or from a
// word-addressed memory region, one register per accepted req/ack transfer.
module freg_ctx_sequencer #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int AW   = 32,
    localparam int IDXW = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            save_req_i,
    input  logic            restore_req_i,
    input  logic [AW-1:0]   base_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            fpu_wb_block_o,
    output logic [IDXW-1:0] freg_raddr_o,
    input  logic [DW-1:0]   freg_rdata_i,
    output logic            freg_we_o,
    output logic [IDXW-1:0] freg_waddr_o,
    output logic [DW-1:0]   freg_wdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [DW-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_idx;
    logic [AW-1:0]   r_base;

    logic            w_last;
    logic [AW-1:0]   w_addr;

    assign w_last = (r_idx == IDXW'(NREG - 1));
    // Byte address wraps modulo 2^AW by plain truncation of the sum.
    assign w_addr = r_base + {{(AW-IDXW-2){1'b0}}, r_idx, 2'b00};

    // Sequencer state, register index and captured base address.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_base  <= '0;
        end else if (clk_en_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (save_req_i) begin
                        r_state <= ST_SAVE;
                        r_idx   <= '0;
                        r_base  <= {base_addr_i[AW-1:2], 2'b00};
                    end else if (restore_req_i) begin
                        r_state <= ST_RESTORE;
                        r_idx   <= '0;
                        r_base  <= {base_addr_i[AW-1:2], 2'b00};
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SAVE, ST_RESTORE: begin
                    if (mem_ack_i) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end else begin
            r_state <= r_state;
        end
    end

    // Output decode from state; the restore write path is combinational so
    // the register file write lands on the same edge as the memory ack.
    always_comb begin
        busy_o         = 1'b0;
        done_o         = 1'b0;
        freg_raddr_o   = '0;
        freg_we_o      = 1'b0;
        freg_waddr_o   = '0;
        freg_wdata_o   = '0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        case (r_state)
            ST_SAVE: begin
                busy_o       = 1'b1;
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = w_addr;
                freg_raddr_o = r_idx;
                mem_wdata_o  = freg_rdata_i;
            end
            ST_RESTORE: begin
                busy_o       = 1'b1;
                mem_req_o    = 1'b1;
                mem_addr_o   = w_addr;
                freg_we_o    = mem_ack_i & clk_en_i;
                freg_waddr_o = r_idx;
                freg_wdata_o = mem_rdata_i;
            end
            ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
        fpu_wb_block_o = busy_o;
    end

endmodule

// File: tb/tb_freg_ctx_sequencer.sv
// Directed bench for freg_ctx_sequencer: regfile and memory models with
// hand-derived expected addresses, data, counts and latencies.
module tb_freg_ctx_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        save_req;
    logic        restore_req;
    logic [31:0] base_addr;
    logic        busy_o, done_o, fpu_wb_block_o;
    logic [4:0]  freg_raddr_o, freg_waddr_o;
    logic [31:0] freg_rdata_i, freg_wdata_o;
    logic        freg_we_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    logic [31:0] f [0:31];
    logic [31:0] st_addr [0:63];
    logic [31:0] st_data [0:63];
    logic [31:0] ld_addr [0:63];
    int st_cnt, ld_cnt, busy_cnt, done_cnt, req_cnt, we_cnt, we_bad;
    int cyc, done_cyc, start_cyc, wt, wcnt;
    logic        prev_req, prev_acc, prev_we;
    logic [31:0] prev_addr, prev_wdata;
    int n_checks = 0;
    int n_errors = 0;

    freg_ctx_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
        .save_req_i(save_req), .restore_req_i(restore_req), .base_addr_i(base_addr),
        .busy_o(busy_o), .done_o(done_o), .fpu_wb_block_o(fpu_wb_block_o),
        .freg_raddr_o(freg_raddr_o), .freg_rdata_i(freg_rdata_i),
        .freg_we_o(freg_we_o), .freg_waddr_o(freg_waddr_o), .freg_wdata_o(freg_wdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    assign freg_rdata_i = f[freg_raddr_o];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: writes land on the edge where freg_we_o is seen.
    always @(posedge clk) begin
        if (freg_we_o) begin
            f[freg_waddr_o] <= freg_wdata_o;
            we_cnt <= we_cnt + 1;
            if (!mem_ack_i) we_bad <= we_bad + 1;
        end
    end

    // Memory model: ack after wt wait cycles, log each accepted transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack_i = 1'b0;
            wcnt      = 0;
            prev_req  = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (mem_req_o) req_cnt++;
            if (mem_req_o && prev_req && !prev_acc)
                check("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o},
                      {prev_we, prev_addr, prev_wdata});
            if (mem_req_o) begin
                if (wcnt >= wt) begin
                    mem_ack_i = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    wcnt++;
                end
                mem_rdata_i = 32'hA5A5_0000 + ((mem_addr_o - 32'h0000_2000) >> 2);
            end else begin
                mem_ack_i = 1'b0;
                wcnt = 0;
            end
            if (mem_req_o && mem_ack_i && clk_en) begin
                if (mem_we_o && st_cnt < 64) begin
                    st_addr[st_cnt] = mem_addr_o;
                    st_data[st_cnt] = mem_wdata_o;
                    st_cnt++;
                end else if (!mem_we_o && ld_cnt < 64) begin
                    ld_addr[ld_cnt] = mem_addr_o;
                    ld_cnt++;
                end
            end
            prev_req   = mem_req_o;
            prev_acc   = mem_ack_i && clk_en;
            prev_we    = mem_we_o;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
        end
    end

    task automatic clr();
        st_cnt = 0; ld_cnt = 0; busy_cnt = 0; done_cnt = 0;
        req_cnt = 0; we_cnt = 0; we_bad = 0;
    endtask

    task automatic start(input logic sv, input logic rs, input logic [31:0] base);
        @(posedge clk); #1;
        save_req = sv; restore_req = rs; base_addr = base;
        @(posedge clk); #1;
        start_cyc = cyc;
        save_req = 1'b0; restore_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < budget);
        check("done_timeout", n < budget, 1'b1);
    endtask

    logic [31:0] hold_a, hold_d;

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; save_req = 1'b0; restore_req = 1'b0;
        base_addr = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        cyc = 0; wt = 0; wcnt = 0; done_cyc = 0; start_cyc = 0;
        clr();
        for (int i = 0; i < 32; i++) f[i] = 32'h3F80_0000 + i;

        @(negedge clk);
        check("reset_outs", {busy_o, done_o, fpu_wb_block_o, mem_req_o, mem_we_o, freg_we_o,
              |freg_raddr_o, |freg_waddr_o, |freg_wdata_o, |mem_addr_o, |mem_wdata_o}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Save at 0x1000, ack every cycle.
        clr(); wt = 0;
        start(1'b1, 1'b0, 32'h0000_1000);
        check("save_busy_start", {busy_o, fpu_wb_block_o, mem_req_o, mem_we_o}, 4'hF);
        wait_done(200);
        check("save_cnt", st_cnt, 32);
        for (int k = 0; k < 32; k++) begin
            check("save_addr", st_addr[k], 32'h0000_1000 + 4 * k);
            check("save_data", st_data[k], 32'h3F80_0000 + k);
        end
        check("save_done_cnt", done_cnt, 1);
        check("save_done_lat", done_cyc - start_cyc, 32);
        check("save_busy_cnt", busy_cnt, 33);

        // Restore from 0x2003 with 2 wait cycles per ack.
        clr(); wt = 2;
        start(1'b0, 1'b1, 32'h0000_2003);
        check("rest_we", {mem_req_o, mem_we_o}, 2'b10);
        wait_done(400);
        check("rest_cnt", ld_cnt, 32);
        for (int k = 0; k < 32; k++) begin
            check("rest_addr", ld_addr[k], 32'h0000_2000 + 4 * k);
            check("rest_f", f[k], 32'hA5A5_0000 + k);
        end
        check("rest_we_cnt", we_cnt, 32);
        check("rest_we_noack", we_bad, 0);
        check("rest_req_cycles", req_cnt, 96);
        check("rest_done_cnt", done_cnt, 1);

        // Both requests together, then a restore pulse mid-save.
        clr(); wt = 0;
        for (int i = 0; i < 32; i++) f[i] = 32'h3F80_0000 + i;
        start(1'b1, 1'b1, 32'h0000_4000);
        check("prio_save", {mem_req_o, mem_we_o}, 2'b11);
        repeat (4) @(posedge clk);
        #1 restore_req = 1'b1;
        @(posedge clk); #1 restore_req = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
        check("prio_idle", busy_o, 1'b0);
        check("prio_done_cnt", done_cnt, 1);
        check("prio_st_cnt", st_cnt, 32);
        check("prio_ld_cnt", ld_cnt, 0);

        // Address wrap-around.
        clr();
        start(1'b1, 1'b0, 32'hFFFF_FFF0);
        wait_done(200);
        check("wrap_cnt", st_cnt, 32);
        check("wrap_a0", st_addr[0], 32'hFFFF_FFF0);
        check("wrap_a3", st_addr[3], 32'hFFFF_FFFC);
        check("wrap_a4", st_addr[4], 32'h0000_0000);
        check("wrap_a5", st_addr[5], 32'h0000_0004);
        check("wrap_a31", st_addr[31], 32'h0000_006C);

        // Asynchronous reset at idx 10 of a restore.
        clr(); wt = 2;
        for (int i = 0; i < 32; i++) f[i] = 32'hDEAD_0000 + i;
        start(1'b0, 1'b1, 32'h0000_2000);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(mem_req_o && freg_waddr_o == 5'd10) && n < 200);
            check("rst_wait_idx10", n < 200, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1 check("rst_async_outs", {busy_o, done_o, fpu_wb_block_o, mem_req_o, mem_we_o, freg_we_o,
              |freg_raddr_o, |freg_waddr_o, |freg_wdata_o, |mem_addr_o, |mem_wdata_o}, 64'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_idle", busy_o, 1'b0);
        check("rst_no_done", done_cnt, 0);
        for (int k = 0; k < 32; k++)
            check("rst_f", f[k], (k < 10) ? 32'hA5A5_0000 + k : 32'hDEAD_0000 + k);

        // Clock enable low for 5 cycles mid-save with ack held high.
        clr(); wt = 0;
        for (int i = 0; i < 32; i++) f[i] = 32'h1234_0000 + i;
        start(1'b1, 1'b0, 32'h0000_3000);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(mem_req_o && mem_addr_o == 32'h0000_3020) && n < 200);
            check("cen_wait_idx8", n < 200, 1'b1);
        end
        @(posedge clk); #1 clk_en = 1'b0;
        hold_a = mem_addr_o;
        hold_d = mem_wdata_o;
        check("cen_addr_at_freeze", hold_a, 32'h0000_3024);
        check("cen_data_at_freeze", hold_d, 32'h1234_0009);
        repeat (5) begin
            @(negedge clk);
            check("cen_hold", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, freg_we_o},
                  {1'b1, 1'b1, 32'h0000_3024, 32'h1234_0009, 1'b0});
            @(posedge clk);
        end
        #1 clk_en = 1'b1;
        wait_done(200);
        check("cen_st_cnt", st_cnt, 32);
        for (int k = 0; k < 32; k++) begin
            check("cen_addr", st_addr[k], 32'h0000_3000 + 4 * k);
            check("cen_data", st_data[k], 32'h1234_0000 + k);
        end
        check("cen_busy_cnt", busy_cnt, 38);
        check("cen_done_cnt", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
